// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine controller: FSM state codes,
// product selection type, prices, coin codes and seven-segment constants.
// Optional feature macro used by the top level: VM_SEVEN_SEG_EN.
package vending_machine_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SEL_TEA    = 3'd1;
  localparam logic [2:0] ST_SEL_COFFEE = 3'd2;
  localparam logic [2:0] ST_SEL_CHOC   = 3'd3;
  localparam logic [2:0] ST_MORE_MONEY = 3'd4;
  localparam logic [2:0] ST_DELIVER    = 3'd5;

  typedef logic [2:0] state_t;

  // Latched product selection
  typedef enum logic [1:0] {
    PROD_NONE   = 2'd0,
    PROD_TEA    = 2'd1,
    PROD_COFFEE = 2'd2,
    PROD_CHOC   = 2'd3
  } product_e;

  // Prices in zloty
  localparam logic [3:0] PRICE_TEA    = 4'd2;
  localparam logic [3:0] PRICE_COFFEE = 4'd3;
  localparam logic [3:0] PRICE_CHOC   = 4'd5;

  // Coin acceptor codes
  localparam logic [2:0] COIN_1 = 3'b001;
  localparam logic [2:0] COIN_2 = 3'b010;
  localparam logic [2:0] COIN_5 = 3'b101;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;

  // Value in zloty of a coin code; zero for "no coin" and invalid codes
  function automatic logic [3:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // True only for the three recognised coin codes
  function automatic logic coin_valid(input logic [2:0] code);
    return (code == COIN_1) || (code == COIN_2) || (code == COIN_5);
  endfunction

  // Price of a selection; zero when nothing is selected
  function automatic logic [3:0] price_of(input product_e p);
    case (p)
      PROD_TEA:    return PRICE_TEA;
      PROD_COFFEE: return PRICE_COFFEE;
      PROD_CHOC:   return PRICE_CHOC;
      default:     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_seven_seg.sv
// Seven-segment decoder: 4-bit decimal digit to {g,f,e,d,c,b,a}, active-high.
// Codes above 9 and the blank request both produce a dark digit.
module seven_seg_decoder
  import vending_machine_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Pure lookup; the register stage lives in the top level
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (value_i)
        4'd0:    seg_o = 7'b0111111;
        4'd1:    seg_o = 7'b0000110;
        4'd2:    seg_o = 7'b1011011;
        4'd3:    seg_o = 7'b1001111;
        4'd4:    seg_o = 7'b1100110;
        4'd5:    seg_o = 7'b1101101;
        4'd6:    seg_o = 7'b1111101;
        4'd7:    seg_o = 7'b0000111;
        4'd8:    seg_o = 7'b1111111;
        4'd9:    seg_o = 7'b1101111;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/vending_machine.sv
// Three-product vending controller (tea 2, coffee 3, hot chocolate 5 zl).
// Takes 1/2/5 zl coins, dispenses the selected product, returns change and
// drives four seven-segment digits plus selection LEDs. Every output is a flop.
// Optional feature: VM_SEVEN_SEG_EN enables the digit decoders; without it
// digit0..digit3 are tied low.
module vending_machine
  import vending_machine_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic [2:0] Money_in,
  output logic       product1,
  output logic       product2,
  output logic       product3,
  output logic       delivered,
  output logic [2:0] Money_out,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic [6:0] digit0,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] digit3
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state_q, state_d;
  product_e         sel_q, sel_d;
  logic [3:0]       credit_q, credit_d;
  logic [2:0]       change_q, change_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [2:0]       coinPrev_q;

  logic             coinEvent;
  logic [4:0]       coinTotal;
  logic [3:0]       price;

  logic             delivered_q, product1_q, product2_q, product3_q;
  logic             led1_q, led2_q, led3_q;

  // A coin counts once, on the first cycle its code follows an all-zero sample
  assign coinEvent = coin_valid(Money_in) && (coinPrev_q == 3'b000);
  assign coinTotal = {1'b0, credit_q} + {1'b0, coin_value(Money_in)};
  assign price     = price_of(sel_q);

  // Next-state logic: selection, coin accumulation and the delivery hold
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    credit_d  = credit_q;
    change_d  = change_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      ST_IDLE: begin
        credit_d = 4'd0;
        change_d = 3'd0;
        sel_d    = PROD_NONE;
        if (BTN1) begin
          sel_d   = PROD_TEA;
          state_d = ST_SEL_TEA;
        end else if (BTN2) begin
          sel_d   = PROD_COFFEE;
          state_d = ST_SEL_COFFEE;
        end else if (BTN3) begin
          sel_d   = PROD_CHOC;
          state_d = ST_SEL_CHOC;
        end
      end
      ST_SEL_TEA, ST_SEL_COFFEE, ST_SEL_CHOC, ST_MORE_MONEY: begin
        if (coinEvent) begin
          credit_d = 4'(coinTotal);
          if (coinTotal >= {1'b0, price}) begin
            state_d   = ST_DELIVER;
            change_d  = 3'(coinTotal - {1'b0, price});
            holdCnt_d = '0;
          end else begin
            state_d = ST_MORE_MONEY;
          end
        end
      end
      ST_DELIVER: begin
        if (holdCnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          sel_d     = PROD_NONE;
          credit_d  = 4'd0;
          change_d  = 3'd0;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sel_d     = PROD_NONE;
        credit_d  = 4'd0;
        change_d  = 3'd0;
        holdCnt_d = '0;
      end
    endcase
  end

  // Core state registers; reset abandons any transaction without change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= PROD_NONE;
      credit_q   <= 4'd0;
      change_q   <= 3'd0;
      holdCnt_q  <= '0;
      coinPrev_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      holdCnt_q  <= holdCnt_d;
      coinPrev_q <= Money_in;
    end
  end

  // Output flops decoded from next-state values so they line up with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delivered_q <= 1'b0;
      product1_q  <= 1'b0;
      product2_q  <= 1'b0;
      product3_q  <= 1'b0;
      led1_q      <= 1'b0;
      led2_q      <= 1'b0;
      led3_q      <= 1'b0;
    end else begin
      delivered_q <= (state_d == ST_DELIVER);
      product1_q  <= (state_d == ST_DELIVER) && (sel_d == PROD_TEA);
      product2_q  <= (state_d == ST_DELIVER) && (sel_d == PROD_COFFEE);
      product3_q  <= (state_d == ST_DELIVER) && (sel_d == PROD_CHOC);
      led1_q      <= (sel_d == PROD_TEA);
      led2_q      <= (sel_d == PROD_COFFEE);
      led3_q      <= (sel_d == PROD_CHOC);
    end
  end

  assign delivered = delivered_q;
  assign product1  = product1_q;
  assign product2  = product2_q;
  assign product3  = product3_q;
  assign LED1      = led1_q;
  assign LED2      = led2_q;
  assign LED3      = led3_q;
  assign Money_out = change_q;

`ifdef VM_SEVEN_SEG_EN
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [6:0] digit0_q, digit1_q, digit2_q, digit3_q;

  seven_seg_decoder u_dig0 (
    .value_i (credit_d),
    .blank_i (1'b0),
    .seg_o   (seg0)
  );

  seven_seg_decoder u_dig1 (
    .value_i (price_of(sel_d)),
    .blank_i (sel_d == PROD_NONE),
    .seg_o   (seg1)
  );

  seven_seg_decoder u_dig2 (
    .value_i (4'd0),
    .blank_i (1'b1),
    .seg_o   (seg2)
  );

  seven_seg_decoder u_dig3 (
    .value_i ({1'b0, change_d}),
    .blank_i (state_d != ST_DELIVER),
    .seg_o   (seg3)
  );

  // Digit registers: credit, selected price, blank, change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit0_q <= SEG_ZERO;
      digit1_q <= SEG_BLANK;
      digit2_q <= SEG_BLANK;
      digit3_q <= SEG_BLANK;
    end else begin
      digit0_q <= seg0;
      digit1_q <= seg1;
      digit2_q <= seg2;
      digit3_q <= seg3;
    end
  end

  assign digit0 = digit0_q;
  assign digit1 = digit1_q;
  assign digit2 = digit2_q;
  assign digit3 = digit3_q;
`else
  assign digit0 = 7'b0000000;
  assign digit1 = 7'b0000000;
  assign digit2 = 7'b0000000;
  assign digit3 = 7'b0000000;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios plus random
// traffic, all compared against a transaction-level model of the machine.
// Digit expectations follow the VM_SEVEN_SEG_EN build setting.
module tb_vending_machine;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0;
  logic [2:0] Money_in = 3'b000;
  logic       product1, product2, product3, delivered;
  logic [2:0] Money_out;
  logic       LED1, LED2, LED3;
  logic [6:0] digit0, digit1, digit2, digit3;

  int checks = 0;
  int errors = 0;

  // Model: selection (0 none, 1 tea, 2 coffee, 3 chocolate), credit in zl,
  // delivery cycles remaining, change owed, last coin sample
  int         mSel, mCredit, mLeft, mChange;
  logic [2:0] mPrev;

  vending_machine #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .BTN1      (BTN1),
    .BTN2      (BTN2),
    .BTN3      (BTN3),
    .Money_in  (Money_in),
    .product1  (product1),
    .product2  (product2),
    .product3  (product3),
    .delivered (delivered),
    .Money_out (Money_out),
    .LED1      (LED1),
    .LED2      (LED2),
    .LED3      (LED3),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3)
  );

  always #5 clk = ~clk;

  logic [37:0] obsVec;
  assign obsVec = {product1, product2, product3, delivered, Money_out,
                   LED1, LED2, LED3, digit0, digit1, digit2, digit3};

  function automatic logic [6:0] segOf(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int priceOf(input int s);
    case (s)
      1: return 2;
      2: return 3;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int coinWorth(input logic [2:0] c);
    case (c)
      3'b001: return 1;
      3'b010: return 2;
      3'b101: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [37:0] expVec();
    logic       del;
    logic [2:0] chg;
    logic [6:0] d0, d1, d2, d3;
    del = (mLeft > 0);
    chg = del ? 3'(mChange) : 3'd0;
`ifdef VM_SEVEN_SEG_EN
    d0 = segOf(mCredit);
    d1 = (mSel != 0) ? segOf(priceOf(mSel)) : 7'h00;
    d2 = 7'h00;
    d3 = del ? segOf(mChange) : 7'h00;
`else
    d0 = 7'h00;
    d1 = 7'h00;
    d2 = 7'h00;
    d3 = 7'h00;
`endif
    return {del && (mSel == 1), del && (mSel == 2), del && (mSel == 3), del, chg,
            mSel == 1, mSel == 2, mSel == 3, d0, d1, d2, d3};
  endfunction

  task automatic modelReset();
    mSel = 0; mCredit = 0; mLeft = 0; mChange = 0; mPrev = 3'b000;
  endtask

  task automatic modelStep();
    int total;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mSel = 0; mCredit = 0; mChange = 0;
      end
    end else if (mSel == 0) begin
      if (BTN1) mSel = 1;
      else if (BTN2) mSel = 2;
      else if (BTN3) mSel = 3;
    end else if (coinWorth(Money_in) != 0 && mPrev == 3'b000) begin
      total = mCredit + coinWorth(Money_in);
      mCredit = total;
      if (total >= priceOf(mSel)) begin
        mChange = total - priceOf(mSel);
        mLeft = HOLD;
      end
    end
    mPrev = Money_in;
  endtask

  // Drive one cycle of inputs (from a negedge), clock it, return at next negedge
  task automatic applyStimulus(input logic [2:0] btn, input logic [2:0] coin);
    {BTN1, BTN2, BTN3} = btn;
    Money_in = coin;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    modelReset();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", obsVec, expVec());
    end
    reset = 1'b1;
    applyStimulus(3'b000, 3'b000);
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", obsVec, expVec());
    end
  endtask

  task automatic test_tea_exact();
    logic [2:0] b [8] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c [8] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(b[i], c[i]);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL tea_exact step %0d: got %h expected %h", i, obsVec, expVec());
      end
      if (i == 2) begin
        checks++;
        if ({delivered, product1, Money_out} !== 5'b11_000) begin
          errors++;
          $display("[TB] FAIL tea_exact_deliver: got %b expected 11000", {delivered, product1, Money_out});
        end
      end
      if (i == 7) begin
        checks++;
        if ({delivered, LED1} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL tea_exact_idle: got %b expected 00", {delivered, LED1});
        end
      end
    end
  endtask

  task automatic test_tea_change();
    logic [2:0] b [7] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c [7] = '{3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(b[i], c[i]);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL tea_change step %0d: got %h expected %h", i, obsVec, expVec());
      end
      if (i == 1) begin
        checks++;
        if ({product1, Money_out} !== 4'b1_011) begin
          errors++;
          $display("[TB] FAIL tea_change_value: got %b expected 1011", {product1, Money_out});
        end
      end
    end
  endtask

  task automatic test_coffee_two_coins();
    logic [2:0] b [9] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c [9] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(b[i], c[i]);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL coffee step %0d: got %h expected %h", i, obsVec, expVec());
      end
      if (i == 1) begin
        checks++;
        if ({delivered, LED2} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL coffee_more_money: got %b expected 01", {delivered, LED2});
        end
      end
      if (i == 3) begin
        checks++;
        if ({product2, Money_out} !== 4'b1_000) begin
          errors++;
          $display("[TB] FAIL coffee_deliver: got %b expected 1000", {product2, Money_out});
        end
      end
    end
  endtask

  task automatic test_choc_three_coins();
    logic [2:0] b [10] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c [10] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(b[i], c[i]);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL choc step %0d: got %h expected %h", i, obsVec, expVec());
      end
      if (i == 5) begin
        checks++;
        if ({product3, Money_out} !== 4'b1_001) begin
          errors++;
          $display("[TB] FAIL choc_deliver: got %b expected 1001", {product3, Money_out});
        end
      end
    end
  endtask

  task automatic test_held_coin();
    applyStimulus(3'b100, 3'b000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b000, 3'b001);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL held_coin step %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
    checks++;
    if (delivered !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_coin_no_deliver: got %b expected 0", delivered);
    end
    applyStimulus(3'b000, 3'b000);
    applyStimulus(3'b000, 3'b001);
    checks++;
    if ({delivered, product1} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL held_coin_deliver: got %b expected 11", {delivered, product1});
    end
    for (int i = 0; i < HOLD; i++) begin
      applyStimulus(3'b000, 3'b000);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL held_coin_tail %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(3'b010, 3'b000);
    applyStimulus(3'b000, 3'b010);
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_mid_before: got %h expected %h", obsVec, expVec());
    end
    #2 reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obsVec !== expVec() || Money_out !== 3'd0 || LED2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got %h expected %h", obsVec, expVec());
    end
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3'b000, 3'b001);
    applyStimulus(3'b000, 3'b000);
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got %h expected %h", obsVec, expVec());
    end
  endtask

  task automatic test_idle_button_coin_priority();
    // Button and coin together: coin ignored and still held next cycle
    logic [2:0] b [14] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                           3'b011, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] c [14] = '{3'b010, 3'b010, 3'b000, 3'b011, 3'b001, 3'b000, 3'b010, 3'b000,
                           3'b000, 3'b000, 3'b101, 3'b101, 3'b000, 3'b000};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(b[i], c[i]);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL idle_prio step %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
    for (int i = 0; i < HOLD; i++) applyStimulus(3'b000, 3'b000);
  endtask

  task automatic test_random();
    logic [2:0] pool [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b000};
    logic [2:0] coin;
    logic [2:0] btn;
    coin = 3'b000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        #2 reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if (obsVec !== expVec()) begin
          errors++;
          $display("[TB] FAIL random_reset %0d: got %h expected %h", i, obsVec, expVec());
        end
        @(negedge clk);
        reset = 1'b1;
      end
      btn = ($urandom_range(0, 99) < 15) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 1) == 0) coin = pool[$urandom_range(0, 7)];
      applyStimulus(btn, coin);
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random step %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelReset();
    test_reset();
    test_tea_exact();
    test_tea_change();
    test_coffee_two_coins();
    test_choc_three_coins();
    test_held_coin();
    test_reset_mid();
    test_idle_button_coin_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
